// File: rtl/mem_frame_responder.sv
// Frame-memory responder: translates (row, col) read requests into frame-SRAM
// addresses, captures NCC result write-backs and sequences the per-frame handshake.
module mem_frame_responder #(
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] TEMPLATE_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] WINDOW_BASE   = 16'h4000,
  parameter int                NUM_SETS      = 150,
  parameter int                RES_AW        = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rd_wr,
  input  logic              tem_win,
  input  logic [6:0]        row,
  input  logic [6:0]        col,
  input  logic [31:0]       write_data,
  input  logic [1:0]        wr_index,
  input  logic              set_done,
  output logic [31:0]       read_data,
  output logic              rd_valid,
  output logic              ready_2_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              frame_loaded,
  input  logic [RES_AW-1:0] res_rd_addr,
  output logic [31:0]       res_rd_data,
  output logic              results_valid,
  output logic [15:0]       frame_count,
  output logic              err
);

  localparam int               PTR_W     = $clog2(NUM_SETS + 1);
  localparam int               RES_DEPTH = 2 ** RES_AW;
  localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(NUM_SETS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  state_e              state_q;
  logic [PTR_W-1:0]    res_ptr_q;
  logic [PTR_W-1:0]    res_ptr_d;
  logic                ready_q;
  logic                results_valid_q;
  logic [15:0]         frame_count_q;
  logic                err_q;
  logic                mem_rd_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                rd_valid_q;
  logic [31:0]         read_data_q;
  logic [31:0]         res_rd_data_q;
  logic [31:0]         res_mem [RES_DEPTH];

  logic                active_s;
  logic                rd_fire_s;
  logic                wr_req_s;
  logic                wr_ok_s;
  logic                close_s;
  logic                err_evt_s;
  logic [ADDR_W-1:0]   rc_ext_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [RES_AW-1:0]   wr_addr_s;

  // Request decode, error detection and result pointer next state
  always_comb begin
    active_s  = (state_q != ST_IDLE);
    rd_fire_s = req & ~rd_wr & active_s;
    wr_req_s  = req & rd_wr & active_s;
    wr_ok_s   = wr_req_s & (wr_index != 2'd3) & (res_ptr_q != PTR_FULL);
    close_s   = set_done & (state_q == ST_BUSY);
    err_evt_s = (req & ~active_s) | (wr_req_s & ~wr_ok_s)
              | (frame_loaded & active_s) | (set_done & ~active_s);
    rc_ext_s  = ADDR_W'({row, col});
    rd_addr_s = (tem_win ? WINDOW_BASE : TEMPLATE_BASE) + rc_ext_s;
    wr_addr_s = RES_AW'(res_ptr_q) * RES_AW'(2'd3) + RES_AW'(wr_index);
    // A write landing with set_done is committed first, then the pointer clears
    if (close_s) begin
      res_ptr_d = {PTR_W{1'b0}};
    end else if (wr_ok_s && (wr_index == 2'd2)) begin
      res_ptr_d = res_ptr_q + PTR_W'(1'b1);
    end else begin
      res_ptr_d = res_ptr_q;
    end
  end

  // Frame sequencing FSM with its registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ready_q         <= 1'b0;
      results_valid_q <= 1'b0;
      frame_count_q   <= 16'd0;
      res_ptr_q       <= {PTR_W{1'b0}};
      err_q           <= 1'b0;
    end else begin
      results_valid_q <= 1'b0;
      res_ptr_q       <= res_ptr_d;
      err_q           <= err_q | err_evt_s;
      case (state_q)
        ST_IDLE: begin
          if (frame_loaded) begin
            state_q <= ST_ARMED;
            ready_q <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (req) begin
            state_q <= ST_BUSY;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          ready_q <= 1'b0;
          if (set_done) begin
            state_q         <= ST_IDLE;
            results_valid_q <= 1'b1;
            frame_count_q   <= frame_count_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-stage read pipeline; mem_rdata is sampled at the edge closing the mem_rd cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      rd_valid_q  <= 1'b0;
      read_data_q <= 32'd0;
    end else begin
      mem_rd_q   <= rd_fire_s;
      rd_valid_q <= mem_rd_q;
      if (rd_fire_s) begin
        mem_addr_q <= rd_addr_s;
      end
      if (mem_rd_q) begin
        read_data_q <= mem_rdata;
      end
    end
  end

  // Result buffer storage, intentionally untouched by reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      res_mem[wr_addr_s] <= write_data;
    end
  end

  // Host read port: registered, returns pre-write data on a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_rd_data_q <= 32'd0;
    end else begin
      res_rd_data_q <= res_mem[res_rd_addr];
    end
  end

  assign read_data     = read_data_q;
  assign rd_valid      = rd_valid_q;
  assign ready_2_start = ready_q;
  assign mem_addr      = mem_addr_q;
  assign mem_rd        = mem_rd_q;
  assign res_rd_data   = res_rd_data_q;
  assign results_valid = results_valid_q;
  assign frame_count   = frame_count_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_frame_responder.sv
// Scoreboard bench for mem_frame_responder: a driver runs a behavioural frame model
// and queues expectations; a monitor pops them when the DUT presents outputs.
module tb_mem_frame_responder;

  localparam int NUM_SETS = 150;
  localparam int RES_AW   = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, rd_wr, tem_win, set_done, frame_loaded;
  logic [6:0]  row, col;
  logic [31:0] write_data, mem_rdata, read_data, res_rd_data;
  logic [1:0]  wr_index;
  logic        rd_valid, ready_2_start, mem_rd, results_valid, err;
  logic [15:0] mem_addr, frame_count;
  logic [RES_AW-1:0] res_rd_addr;

  mem_frame_responder dut (
    .clk(clk), .rst(rst), .req(req), .rd_wr(rd_wr), .tem_win(tem_win),
    .row(row), .col(col), .write_data(write_data), .wr_index(wr_index),
    .set_done(set_done), .read_data(read_data), .rd_valid(rd_valid),
    .ready_2_start(ready_2_start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .frame_loaded(frame_loaded), .res_rd_addr(res_rd_addr),
    .res_rd_data(res_rd_data), .results_valid(results_valid),
    .frame_count(frame_count), .err(err)
  );

  function automatic logic [31:0] sram_word(input logic [15:0] a);
    if (a == 16'h0185) return 32'hDEADBEEF;
    return {a ^ 16'hA5C3, ~a};
  endfunction

  assign mem_rdata = sram_word(mem_addr);

  typedef struct packed {
    logic        ready;
    logic        err;
    logic        rv;
    logic [15:0] fc;
    logic        hchk;
    logic [31:0] hdata;
  } status_t;

  status_t     st_q[$];
  logic [15:0] addr_q[$];
  logic [31:0] rdat_q[$];

  // Behavioural model of the frame protocol
  bit          m_open, m_started, m_err;
  int          m_ptr, m_fc;
  logic [31:0] m_buf[512];
  bit          m_known[512];

  int n_vec = 0;
  int n_bad = 0;
  bit host_hold = 1'b0;
  int host_max  = 29;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    status_t s;
    bit o_open, o_started;
    int idx;
    logic [15:0] a;
    s = '0;
    if (rst) begin
      m_open = 0; m_started = 0; m_err = 0; m_ptr = 0; m_fc = 0;
      addr_q.delete();
      rdat_q.delete();
      s.hchk = 1'b1;
    end else begin
      o_open = m_open;
      o_started = m_started;
      s.hchk  = m_known[res_rd_addr];
      s.hdata = m_buf[res_rd_addr];
      if (req && !o_open) m_err = 1;
      if (req && o_open && !rd_wr) begin
        a = 16'((tem_win ? 32'h4000 : 32'h0) + int'(row) * 128 + int'(col));
        addr_q.push_back(a);
        rdat_q.push_back(sram_word(a));
      end
      if (req && o_open && rd_wr) begin
        if (wr_index == 2'd3 || m_ptr == NUM_SETS) begin
          m_err = 1;
        end else begin
          idx = m_ptr * 3 + int'(wr_index);
          m_buf[idx] = write_data;
          m_known[idx] = 1;
          if (wr_index == 2'd2) m_ptr++;
        end
      end
      if (frame_loaded) begin
        if (o_open) m_err = 1;
        else begin m_open = 1; m_started = 0; end
      end
      if (o_open && !o_started && req) m_started = 1;
      if (set_done) begin
        if (!o_open) m_err = 1;
        else if (o_started) begin
          m_open = 0; m_started = 0; m_ptr = 0;
          m_fc = (m_fc + 1) % 65536;
          s.rv = 1'b1;
        end
      end
    end
    s.ready = m_open && !m_started;
    s.err   = m_err;
    s.fc    = 16'(m_fc);
    st_q.push_back(s);
  endtask

  task automatic step();
    if (!host_hold) res_rd_addr = RES_AW'($urandom_range(0, host_max));
    model_cycle();
    @(negedge clk);
    req = 1'b0; set_done = 1'b0; frame_loaded = 1'b0;
  endtask

  task automatic do_read(input bit tw, input int r, input int c);
    req = 1'b1; rd_wr = 1'b0; tem_win = tw; row = 7'(r); col = 7'(c);
    step();
  endtask

  task automatic do_write(input int idx, input logic [31:0] d);
    req = 1'b1; rd_wr = 1'b1; wr_index = 2'(idx); write_data = d;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Monitor: compare DUT outputs against queued expectations one tick after each edge
  initial begin
    status_t s;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check("ready_2_start", 32'(ready_2_start), 32'(s.ready));
        check("err", 32'(err), 32'(s.err));
        check("frame_count", 32'(frame_count), 32'(s.fc));
        check("results_valid", 32'(results_valid), 32'(s.rv));
        if (s.hchk) check("res_rd_data", res_rd_data, s.hdata);
      end
      if (mem_rd) begin
        if (addr_q.size() == 0) check("unexpected mem_rd", 32'(mem_rd), 32'd0);
        else check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (rd_valid) begin
        if (rdat_q.size() == 0) check("unexpected rd_valid", 32'(rd_valid), 32'd0);
        else check("read_data", read_data, rdat_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; rd_wr = 1'b0; tem_win = 1'b0; row = 7'd0; col = 7'd0;
    write_data = 32'd0; wr_index = 2'd0; set_done = 1'b0; frame_loaded = 1'b0;
    res_rd_addr = '0;
    @(negedge clk);
    idle(3);
    rst = 1'b0;
    idle(2);

    // Reset while a read is in flight: its data must never be returned
    frame_loaded = 1'b1; step();
    step();
    do_read(0, 3, 5);
    rst = 1'b1; idle(2);
    rst = 1'b0; idle(2);

    // Directed reads, including the region boundary case
    frame_loaded = 1'b1; step();
    step();
    do_read(0, 3, 5);
    do_read(1, 1, 2);
    do_read(0, 127, 127);
    idle(3);

    // Two result sets plus one word of a third, then host readback
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 3; i++) do_write(i, 32'(32'hA0 + s * 3 + i));
    do_write(0, 32'hA6);
    host_hold = 1'b1;
    for (int a = 0; a < 7; a++) begin
      res_rd_addr = RES_AW'(a);
      step();
    end
    host_hold = 1'b0;
    set_done = 1'b1; step();
    idle(4);

    // Legal random traffic across several frames
    for (int n = 0; n < 500; n++) begin
      if (!m_open) begin
        frame_loaded = ($urandom_range(0, 3) == 0);
      end else begin
        set_done = m_started && ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) < 7) begin
          req = 1'b1; rd_wr = 1'($urandom_range(0, 1));
          tem_win = 1'($urandom_range(0, 1));
          row = 7'($urandom_range(0, 127)); col = 7'($urandom_range(0, 127));
          wr_index = 2'($urandom_range(0, 2)); write_data = $urandom;
          if (m_ptr == NUM_SETS) rd_wr = 1'b0;
        end
      end
      step();
    end

    // Close any open frame, then drive each error case
    if (m_open) begin
      if (!m_started) do_read(0, 0, 0);
      set_done = 1'b1; step();
    end
    idle(2);
    do_read(0, 1, 1);
    frame_loaded = 1'b1; step();
    do_write(3, 32'hBAD00003);
    host_max = 3 * NUM_SETS - 1;
    for (int s = 0; s < NUM_SETS; s++)
      for (int i = 0; i < 3; i++) do_write(i, $urandom);
    do_write(0, 32'hBAD00151);
    frame_loaded = 1'b1; step();
    host_hold = 1'b1;
    for (int a = 0; a < 3 * NUM_SETS + 2; a++) begin
      res_rd_addr = RES_AW'(a);
      step();
    end
    host_hold = 1'b0;
    set_done = 1'b1; step();
    idle(2);

    // Unconstrained random traffic with occasional resets
    host_max = 40;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      req = 1'($urandom_range(0, 1)); rd_wr = 1'($urandom_range(0, 1));
      tem_win = 1'($urandom_range(0, 1));
      row = 7'($urandom_range(0, 127)); col = 7'($urandom_range(0, 127));
      wr_index = 2'($urandom_range(0, 3)); write_data = $urandom;
      frame_loaded = ($urandom_range(0, 9) == 0);
      set_done = ($urandom_range(0, 14) == 0);
      step();
    end
    rst = 1'b0;
    idle(5);

    check("reads outstanding", 32'(addr_q.size() + rdat_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
